mmio_button_ctrl: RTL
=====================

// Module: mmio_button_ctrl
// PURPOSE
//  Memory-mapped button peripheral between processor data port, data RAM and board pushbuttons.
//  Synchronises and debounces N_BTN raw buttons; exposes four registers: code, level, sticky press events, IRQ mask.
//  Steers the processor read-data bus: window hits return register data, all other addresses return RAM data.
//  Read timing matches the synchronous RAM.
// PARAMETERS
//  N_BTN            4       number of raw button inputs (1..15)
//  DEBOUNCE_CYCLES  290000  cycles an input must hold a new level before acceptance (~10 ms at 29 MHz); >=2
//  ADDR_W           12      width of the data address compared by the block
//  BASE_ADDR        0       word address of register 0; must be a multiple of 4
// PORTS
//  clock      in   1       system clock, all state on posedge
//  reset      in   1       asynchronous, active-low reset
//  btn_raw    in   N_BTN   raw pushbutton levels, asynchronous, 1 = pressed
//  addr       in   ADDR_W  processor data address (word)
//  wren       in   1       processor data write enable
//  data_in    in   32      processor store data
//  dmem_q     in   32      data-RAM read data (valid one cycle after addr)
//  q_out      out  32      read data to processor q_dmem
//  irq        out  1       level interrupt: |(EVENT & IRQ_EN)
// BEHAVIOUR
//  Window: hit = (addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]); off = addr[1:0]
//  Register map:
//   off 0  CODE    RO  0 = none pressed; i+1 = lowest-index debounced pressed button i; width clog2(N_BTN+1), zero-extended
//   off 1  STATE   RO  debounced levels [N_BTN-1:0], zero-extended
//   off 2  EVENT   W1C sticky press flags; bit i set on debounced 0->1 of button i
//   off 3  IRQ_EN  RW  interrupt mask [N_BTN-1:0]; upper write bits ignored
//  Input path per button: 2-flop synchroniser -> debouncer -> stable level
//   cnt width = clog2(DEBOUNCE_CYCLES+1)
//   sync == stable: cnt <= 0
//   sync != stable and cnt < DEBOUNCE_CYCLES-1: cnt++
//   sync != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0
//   Glitches shorter than DEBOUNCE_CYCLES restart the count and are never accepted
//   Accepted change visible in STATE 2 + DEBOUNCE_CYCLES cycles after a clean raw edge
//  Edge: rise_i = stable_i & ~stable_d_i; EVENT_i <= 1 on rise_i
//  W1C: wren & hit & off==2 clears EVENT bits where data_in = 1
//   Simultaneous set and clear of the same bit: set wins, bit stays 1
//  Writes to CODE or STATE are ignored; non-hit writes are ignored by this block (RAM handles them)
//  Read path, 1-cycle latency:
//   posedge: sel_q <= hit; rdata_q <= register selected by off
//   q_out = sel_q ? rdata_q : dmem_q   (combinational mux, no added latency on RAM path)
//   Read and W1C at the same address in the same cycle return pre-clear EVENT value
//  irq is combinational from EVENT and IRQ_EN; no extra register stage
//  Reset (reset=0, asynchronous):
//   synchronisers, stable, stable_d, cnt, EVENT, IRQ_EN, sel_q and rdata_q cleared
//   q_out = dmem_q; irq = 0
//   Reset asserted mid-debounce discards the count
//   Buttons held through reset release: accepted after full debounce and raise EVENT (stable restarts at 0)
// TESTING  (bench uses DEBOUNCE_CYCLES=4, N_BTN=4, BASE_ADDR=0)
//  1 Read addr 5, dmem_q=32'hDEAD_BEEF -> q_out=DEADBEEF one cycle later
//    Read addr 1 with no button pressed -> q_out=0
//  2 btn_raw[2]=1 held -> STATE=4 and CODE=3 exactly 6 cycles after the edge; EVENT=4
//    Then press btn[0] too -> CODE=1
//  3 btn_raw[1] pulsed high for 3 cycles -> STATE, EVENT stay 0
//    Held 4 cycles -> STATE=2, EVENT=2
//  4 EVENT=6; write addr 2 data 2 -> EVENT=4
//    Write-1-clear bit 2 in the same cycle as a new rise on btn 2 -> EVENT bit 2 stays 1
//  5 Write IRQ_EN=1, press btn0 -> irq=1 once EVENT[0] sets
//    Clear EVENT[0] -> irq=0
//    Press btn3 with IRQ_EN=1 -> irq stays 0
//  6 Assert reset while btn0 held mid-count -> all registers read 0, irq=0
//    Release reset with btn held -> STATE=1, EVENT=1 after 6 cycles

Source files
------------

// File: rtl/mmio_button_ctrl_if.sv
// Processor data-port bundle for the button peripheral.
//   addr     processor word address
//   wren     processor write enable
//   data_in  processor store data
//   dmem_q   data-RAM read data, valid one cycle after addr
//   q_out    steered read data back to the processor
// The master side also drives dmem_q: the SoC fabric that owns the processor
// port owns the RAM read data wiring as well.
interface mmio_button_ctrl_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [ADDR_W-1:0] addr;
    logic              wren;
    logic [31:0]       data_in;
    logic [31:0]       dmem_q;
    logic [31:0]       q_out;

    modport master (
        output addr,
        output wren,
        output data_in,
        output dmem_q,
        input  q_out
    );

    modport slave (
        input  addr,
        input  wren,
        input  data_in,
        input  dmem_q,
        output q_out
    );
endinterface

// File: rtl/mmio_button_ctrl.sv
// Memory-mapped pushbutton peripheral.
// Synchronises and debounces N_BTN raw buttons and exposes four word registers
// at BASE_ADDR: CODE (RO), STATE (RO), EVENT (W1C sticky presses), IRQ_EN (RW).
// Window hits return register data one cycle after the address, matching the
// synchronous data RAM; every other address returns dmem_q unchanged.
// Ports:
//   clock    system clock, all state on posedge
//   reset    asynchronous active-low reset
//   btn_raw  raw asynchronous button levels, 1 = pressed
//   irq      level interrupt, |(EVENT & IRQ_EN)
//   bus      processor data port (addr, wren, data_in, dmem_q in; q_out out)
module mmio_button_ctrl #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 290000,
    parameter int unsigned ADDR_W          = 12,
    parameter int unsigned BASE_ADDR       = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_BTN-1:0]   btn_raw,
    output logic               irq,
    mmio_button_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned CODE_W = $clog2(N_BTN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    // Input path state
    logic [N_BTN-1:0]            sync1_q, sync2_q;
    logic [N_BTN-1:0]            stable_q, stable_d;
    logic [N_BTN-1:0]            stable_prev_q;
    logic [N_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Register file state
    logic [N_BTN-1:0] event_q, event_d;
    logic [N_BTN-1:0] irq_en_q, irq_en_d;
    logic             sel_q;
    logic [31:0]      rdata_q, rdata_d;

    logic             hit;
    logic [1:0]       off;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] event_clr;
    logic [CODE_W-1:0] code;

    assign hit = (bus.addr[ADDR_W-1:2] == BASE[ADDR_W-1:2]);
    assign off = bus.addr[1:0];

    // Store bits above the button count have no destination.
    logic unused_data_in;
    assign unused_data_in = ^bus.data_in[31:N_BTN];

    // Debounce: a differing synchronised level must persist for
    // DEBOUNCE_CYCLES consecutive cycles; any return to the stable level
    // restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = stable_q & ~stable_prev_q;

    // Lowest-index pressed button wins; scanning downward lets it overwrite.
    always_comb begin
        code = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (stable_q[i]) begin
                code = CODE_W'(i + 1);
            end
        end
    end

    always_comb begin
        event_clr = '0;
        irq_en_d  = irq_en_q;
        if (bus.wren && hit) begin
            if (off == 2'd2) begin
                event_clr = bus.data_in[N_BTN-1:0];
            end
            if (off == 2'd3) begin
                irq_en_d = bus.data_in[N_BTN-1:0];
            end
        end
        // A rise in the same cycle as a clear keeps the flag set.
        event_d = (event_q & ~event_clr) | rise;
    end

    // Read data captured from the current (pre-write) register values.
    always_comb begin
        rdata_d = '0;
        case (off)
            2'd0:    rdata_d = 32'(code);
            2'd1:    rdata_d = 32'(stable_q);
            2'd2:    rdata_d = 32'(event_q);
            default: rdata_d = 32'(irq_en_q);
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            cnt_q         <= '0;
            event_q       <= '0;
            irq_en_q      <= '0;
            sel_q         <= 1'b0;
            rdata_q       <= '0;
        end else begin
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
            event_q       <= event_d;
            irq_en_q      <= irq_en_d;
            sel_q         <= hit;
            rdata_q       <= rdata_d;
        end
    end

    // RAM path is a pure mux so it adds no latency beyond the RAM's own.
    assign bus.q_out = sel_q ? rdata_q : bus.dmem_q;
    assign irq       = |(event_q & irq_en_q);

endmodule
